// File: rtl/msrv_32_lsu.sv
// Load/store unit: one req/ack data-bus transaction per access, with byte-lane steering and load extension.
// Optional bus timeout is enabled by defining MSRV_LSU_TIMEOUT_EN; TIMEOUT_CYCLES sets the limit.
module msrv_32_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        load_req_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        misaligned_load_in,
  input  logic        misaligned_store_in,
  input  logic        trap_taken_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wstrb_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_err_in,
  output logic        lsu_stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        access_fault_out
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef struct packed {
    logic [1:0] lo;
    logic [1:0] size;
    logic       uns;
  } acc_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("TIMEOUT_CYCLES out of range 1..255");
  end

  state_t      state, state_nxt;
  acc_t        acc;
  logic        start, to_hit;
  logic [31:0] wdata_s, shifted, ext;
  logic [3:0]  wstrb_s;

`ifdef MSRV_LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
  // Fires on the BUSY cycle that would bring the count to the limit; ack still takes priority.
  assign to_hit = (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  assign start = (load_req_in | mem_wr_req_in) & ~trap_taken_in &
                 ~misaligned_load_in & ~misaligned_store_in;
  assign lsu_stall_out = ((state == IDLE) & start) | (state == BUSY);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (dmem_ack_in || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) state <= IDLE;
    else                      state <= state_nxt;
  end

  always_comb begin
    wdata_s = store_data_in;
    wstrb_s = 4'b1111;
    case (load_size_in)
      2'b00: begin
        wdata_s = {4{store_data_in[7:0]}};
        wstrb_s = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        wdata_s = {2{store_data_in[15:0]}};
        wstrb_s = addr_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = dmem_rdata_in >> {acc.lo, 3'b000};
    case (acc.size)
      2'b00:   ext = acc.uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = acc.uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      dmem_req_out     <= 1'b0;
      dmem_we_out      <= 1'b0;
      dmem_addr_out    <= '0;
      dmem_wdata_out   <= '0;
      dmem_wstrb_out   <= '0;
      load_data_out    <= '0;
      load_valid_out   <= 1'b0;
      access_fault_out <= 1'b0;
      acc              <= '0;
`ifdef MSRV_LSU_TIMEOUT_EN
      to_cnt           <= '0;
`endif
    end else begin
      load_valid_out   <= 1'b0;
      access_fault_out <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dmem_req_out   <= 1'b1;
          dmem_we_out    <= mem_wr_req_in;
          dmem_addr_out  <= {addr_in[31:2], 2'b00};
          dmem_wdata_out <= wdata_s;
          dmem_wstrb_out <= mem_wr_req_in ? wstrb_s : 4'b0000;
          acc            <= '{lo: addr_in[1:0], size: load_size_in, uns: load_unsigned_in};
`ifdef MSRV_LSU_TIMEOUT_EN
          to_cnt         <= '0;
`endif
        end
        BUSY: begin
          if (dmem_ack_in) begin
            dmem_req_out <= 1'b0;
            if (dmem_err_in) access_fault_out <= 1'b1;
            else if (!dmem_we_out) begin
              load_valid_out <= 1'b1;
              load_data_out  <= ext;
            end
          end else if (to_hit) begin
            dmem_req_out     <= 1'b0;
            access_fault_out <= 1'b1;
          end
`ifdef MSRV_LSU_TIMEOUT_EN
          else to_cnt <= to_cnt + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_msrv_32_lsu.sv
// Directed bench for msrv_32_lsu: vector table of single accesses plus hand-written corner sequences.
module tb_msrv_32_lsu;
  logic clk = 1'b0, rst = 1'b1;
  logic load_req = 0, wr_req = 0, uns = 0, mis_ld = 0, mis_st = 0, trap = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, sdata = 0, rdata = 0;
  logic ack = 0, err = 0;
  logic req, we, stall, lvalid, fault;
  logic [31:0] baddr, wdata, ldata;
  logic [3:0] wstrb;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  msrv_32_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .load_req_in(load_req), .mem_wr_req_in(wr_req), .load_size_in(size),
    .load_unsigned_in(uns), .misaligned_load_in(mis_ld), .misaligned_store_in(mis_st),
    .trap_taken_in(trap), .addr_in(addr), .store_data_in(sdata),
    .dmem_req_out(req), .dmem_we_out(we), .dmem_addr_out(baddr), .dmem_wdata_out(wdata),
    .dmem_wstrb_out(wstrb), .dmem_ack_in(ack), .dmem_rdata_in(rdata), .dmem_err_in(err),
    .lsu_stall_out(stall), .load_data_out(ldata), .load_valid_out(lvalid),
    .access_fault_out(fault));

  typedef struct {
    logic ld, wr; logic [1:0] sz; logic un;
    logic [31:0] a, sd, rd; logic er; int dly;
    logic ewe; logic [31:0] ewd; logic [3:0] ews;
    logic chkd; logic [31:0] edata; logic evld, eflt;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    load_req = 0; wr_req = 0; mis_ld = 0; mis_st = 0; trap = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] a0;
    a0 = {v.a[31:2], 2'b00};
    @(negedge clk);
    load_req = v.ld; wr_req = v.wr; size = v.sz; uns = v.un; addr = v.a; sdata = v.sd;
    #1 chk($sformatf("v%0d stall_start", idx), 32'(stall), 32'd1);
    @(negedge clk);
    clear_req(); addr = 32'hFFFF_FFFF; sdata = 32'h5555_5555;
    chk($sformatf("v%0d req", idx), 32'(req), 32'd1);
    chk($sformatf("v%0d we", idx), 32'(we), 32'(v.ewe));
    chk($sformatf("v%0d addr", idx), baddr, a0);
    chk($sformatf("v%0d wstrb", idx), 32'(wstrb), 32'(v.ews));
    if (v.ewe) chk($sformatf("v%0d wdata", idx), wdata, v.ewd);
    for (int i = 0; i < v.dly; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d req_hold", idx), 32'(req), 32'd1);
      chk($sformatf("v%0d addr_hold", idx), baddr, a0);
      chk($sformatf("v%0d stall_busy", idx), 32'(stall), 32'd1);
    end
    ack = 1; rdata = v.rd; err = v.er;
    @(negedge clk);
    ack = 0; err = 0; rdata = 32'hA5A5_A5A5;
    chk($sformatf("v%0d req_drop", idx), 32'(req), 32'd0);
    chk($sformatf("v%0d stall_resp", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d valid", idx), 32'(lvalid), 32'(v.evld));
    chk($sformatf("v%0d fault", idx), 32'(fault), 32'(v.eflt));
    if (v.chkd) chk($sformatf("v%0d data", idx), ldata, v.edata);
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", idx), 32'(lvalid | fault), 32'd0);
  endtask

  task automatic no_start(input string name, input logic l, input logic w,
                          input logic ml, input logic ms, input logic tr);
    @(negedge clk);
    load_req = l; wr_req = w; mis_ld = ml; mis_st = ms; trap = tr; size = 2'b10; addr = 32'h100;
    #1 chk({name, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({name, " req"}, 32'(req), 32'd0);
    clear_req();
    @(negedge clk);
    chk({name, " pulses"}, 32'(lvalid | fault), 32'd0);
  endtask

  initial begin
    //         ld wr sz    un a           sd            rd            er dly we wdata         strb     chk data           vld flt
    vecs[0]  = '{1,0,2'b00,0,32'h1003,32'h0,        32'h80FF_FF12,0,0, 0,32'h0,        4'b0000,1,32'hFFFF_FF80,1,0};
    vecs[1]  = '{0,1,2'b01,0,32'h2002,32'h1234_ABCD,32'h0,        0,0, 1,32'hABCD_ABCD,4'b1100,1,32'hFFFF_FF80,0,0};
    vecs[2]  = '{1,0,2'b01,1,32'h0010,32'h0,        32'h0000_8001,0,5, 0,32'h0,        4'b0000,1,32'h0000_8001,1,0};
    vecs[3]  = '{0,1,2'b00,0,32'h0005,32'h0000_00EF,32'h0,        0,1, 1,32'hEFEF_EFEF,4'b0010,0,32'h0,        0,0};
    vecs[4]  = '{1,0,2'b01,0,32'h0022,32'h0,        32'h8001_1234,0,0, 0,32'h0,        4'b0000,1,32'hFFFF_8001,1,0};
    vecs[5]  = '{1,0,2'b00,1,32'h0031,32'h0,        32'h0000_9A00,0,2, 0,32'h0,        4'b0000,1,32'h0000_009A,1,0};
    vecs[6]  = '{1,0,2'b10,0,32'h0040,32'h0,        32'hDEAD_BEEF,0,0, 0,32'h0,        4'b0000,1,32'hDEAD_BEEF,1,0};
    vecs[7]  = '{0,1,2'b10,0,32'h0044,32'hCAFE_F00D,32'h0,        1,0, 1,32'hCAFE_F00D,4'b1111,0,32'h0,        0,1};
    vecs[8]  = '{1,0,2'b11,1,32'h0048,32'h0,        32'h0123_4567,0,0, 0,32'h0,        4'b0000,1,32'h0123_4567,1,0};
    vecs[9]  = '{1,1,2'b00,0,32'h0003,32'h0000_0077,32'hFFFF_FFFF,0,0, 1,32'h7777_7777,4'b1000,1,32'h0123_4567,0,0};
    vecs[10] = '{1,0,2'b10,0,32'h004C,32'h0,        32'h9999_9999,1,1, 0,32'h0,        4'b0000,1,32'h0123_4567,0,1};
    vecs[11] = '{0,1,2'b01,0,32'h0000,32'h0000_BEEF,32'h0,        0,0, 1,32'hBEEF_BEEF,4'b0011,0,32'h0,        0,0};

    repeat (2) @(negedge clk);
    chk("rst req", 32'(req), 32'd0);
    chk("rst bus", baddr | wdata | 32'(wstrb) | 32'(we), 32'd0);
    chk("rst load", ldata | 32'(lvalid) | 32'(fault), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle stall", 32'(stall), 32'd0);

    // Stray ack while idle must not produce anything.
    ack = 1; err = 1;
    @(negedge clk);
    ack = 0; err = 0;
    @(negedge clk);
    chk("idle ack", 32'(req | lvalid | fault), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    no_start("misld", 1, 0, 1, 0, 0);
    no_start("trap", 1, 0, 0, 0, 1);
    no_start("misst", 0, 1, 0, 1, 0);

    // Reset during BUSY, then a late ack.
    @(negedge clk);
    wr_req = 1; size = 2'b10; addr = 32'h3000; sdata = 32'h1111_2222;
    @(negedge clk);
    clear_req();
    chk("mid req", 32'(req), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("mid rst req", 32'(req), 32'd0);
    chk("mid rst bus", baddr | wdata | 32'(wstrb) | 32'(we), 32'd0);
    chk("mid rst load", ldata | 32'(lvalid) | 32'(fault) | 32'(stall), 32'd0);
    rst = 0; ack = 1;
    @(negedge clk);
    ack = 0;
    @(negedge clk);
    chk("late ack", 32'(req | lvalid | fault), 32'd0);

    // No ack: timeout build faults after 4 BUSY cycles, default build waits.
    @(negedge clk);
    load_req = 1; size = 2'b10; uns = 0; addr = 32'h80;
    @(negedge clk);
    clear_req();
`ifdef MSRV_LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("to req4", 32'(req), 32'd1);
    @(negedge clk);
    chk("to req drop", 32'(req), 32'd0);
    chk("to fault", 32'(fault), 32'd1);
    chk("to valid", 32'(lvalid), 32'd0);
    @(negedge clk);
    chk("to idle", 32'(fault | stall | req), 32'd0);
`else
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("wait req", 32'(req), 32'd1);
    chk("wait stall", 32'(stall), 32'd1);
    chk("wait fault", 32'(fault), 32'd0);
    ack = 1; rdata = 32'h0000_0011;
    @(negedge clk);
    ack = 0;
    chk("wait valid", 32'(lvalid), 32'd1);
    chk("wait data", ldata, 32'h0000_0011);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
